// File: rtl/sccb_byte_writer.sv
`default_nettype none
// ============================================================================
//  Module      : sccb_byte_writer
//  Description : SCCB (I2C-like) byte transmitter. Each accepted byte is sent
//                MSB first with a don't-care ACK slot. A START is issued when
//                leaving IDLE, and a STOP is issued when lastTransfer was
//                latched with the byte. Otherwise the bus is parked in HOLD
//                (scl low) so the next byte can follow without a repeated
//                START. All timing is in quarter SCL periods of CLK_DIV clocks.
//  Options     : define SCCB_ACK_CHECK_EN to add the sdaIn/ackErr
//                ACK-sampling logic.
//  Revision    : 1.0 - initial release
// ============================================================================
module sccb_byte_writer #(
    parameter int CLK_DIV = 125
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       i2cStrobe,
    input  logic [7:0] dataToSend,
    input  logic       lastTransfer,
    output logic       sda,
    output logic       scl,
    output logic       busy
`ifdef SCCB_ACK_CHECK_EN
    ,
    input  logic       sdaIn,
    output logic       ackErr
`endif
);

    // Reload value for the quarter-period down counter.
    localparam logic [15:0] QTR_LOAD = 16'(CLK_DIV - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_BIT   = 3'd2,
        S_ACK   = 3'd3,
        S_HOLD  = 3'd4,
        S_STOP  = 3'd5
    } state_t;

    state_t      state_q;
    logic [15:0] cnt_q;
    logic [1:0]  qtr_q;
    logic [2:0]  bit_q;
    logic [7:0]  data_q;
    logic        last_q;
    logic        sda_q;
    logic        scl_q;
    logic        busy_q;
`ifdef SCCB_ACK_CHECK_EN
    logic        ackErr_q;
`endif

    // Bus sequencer: state, quarter timing and registered line levels.
    // Line levels are set on the edge that enters each quarter, so the
    // outputs always describe the quarter currently in progress.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            cnt_q    <= 16'd0;
            qtr_q    <= 2'd0;
            bit_q    <= 3'd0;
            data_q   <= 8'd0;
            last_q   <= 1'b0;
            sda_q    <= 1'b1;
            scl_q    <= 1'b1;
            busy_q   <= 1'b0;
`ifdef SCCB_ACK_CHECK_EN
            ackErr_q <= 1'b0;
`endif
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (i2cStrobe) begin
                        data_q  <= dataToSend;
                        last_q  <= lastTransfer;
                        cnt_q   <= QTR_LOAD;
                        qtr_q   <= 2'd0;
                        state_q <= S_START;
                        sda_q   <= 1'b0;      // START: sda falls while scl high
                        scl_q   <= 1'b1;
                        busy_q  <= 1'b1;
                    end
                end
                S_HOLD: begin
                    if (i2cStrobe) begin
                        data_q  <= dataToSend;
                        last_q  <= lastTransfer;
                        cnt_q   <= QTR_LOAD;
                        qtr_q   <= 2'd0;
                        bit_q   <= 3'd7;
                        state_q <= S_BIT;     // bus already owned: no START
                        sda_q   <= dataToSend[7];
                        scl_q   <= 1'b0;
                        busy_q  <= 1'b1;
                    end
                end
                default: begin
                    if (cnt_q != 16'd0) begin
                        cnt_q <= cnt_q - 16'd1;
                    end else begin
                        // Quarter boundary: program the next quarter.
                        cnt_q <= QTR_LOAD;
                        qtr_q <= qtr_q + 2'd1;
                        case (state_q)
                            S_START: begin
                                if (qtr_q == 2'd0) begin
                                    scl_q <= 1'b0;
                                end else begin
                                    state_q <= S_BIT;
                                    qtr_q   <= 2'd0;
                                    bit_q   <= 3'd7;
                                    sda_q   <= data_q[7];
                                end
                            end
                            S_BIT: begin
                                case (qtr_q)
                                    2'd1: scl_q <= 1'b1;
                                    2'd3: begin
                                        scl_q <= 1'b0;
                                        qtr_q <= 2'd0;
                                        if (bit_q == 3'd0) begin
                                            state_q <= S_ACK;
                                            sda_q   <= 1'b1;  // release for ACK slot
                                        end else begin
                                            bit_q <= bit_q - 3'd1;
                                            sda_q <= data_q[bit_q - 3'd1];
                                        end
                                    end
                                    default: ;
                                endcase
                            end
                            S_ACK: begin
                                case (qtr_q)
                                    2'd1: scl_q <= 1'b1;
`ifdef SCCB_ACK_CHECK_EN
                                    // Last cycle of the first scl-high quarter:
                                    // a released (high) line means no ACK.
                                    2'd2: ackErr_q <= ackErr_q | sdaIn;
`endif
                                    2'd3: begin
                                        scl_q <= 1'b0;
                                        qtr_q <= 2'd0;
                                        if (last_q) begin
                                            state_q <= S_STOP;
                                            sda_q   <= 1'b0;
                                        end else begin
                                            state_q <= S_HOLD;
                                            sda_q   <= 1'b1;
                                            busy_q  <= 1'b0;
                                            cnt_q   <= 16'd0;
                                        end
                                    end
                                    default: ;
                                endcase
                            end
                            S_STOP: begin
                                case (qtr_q)
                                    2'd0: scl_q <= 1'b1;
                                    2'd1: sda_q <= 1'b1;  // STOP: sda rises while scl high
                                    default: begin
                                        state_q <= S_IDLE;
                                        qtr_q   <= 2'd0;
                                        cnt_q   <= 16'd0;
                                        busy_q  <= 1'b0;
                                    end
                                endcase
                            end
                            default: begin
                                state_q <= S_IDLE;
                                sda_q   <= 1'b1;
                                scl_q   <= 1'b1;
                                busy_q  <= 1'b0;
                            end
                        endcase
                    end
                end
            endcase
        end
    end

    assign sda  = sda_q;
    assign scl  = scl_q;
    assign busy = busy_q;
`ifdef SCCB_ACK_CHECK_EN
    assign ackErr = ackErr_q;
`endif

endmodule
`default_nettype wire

// File: doc/sccb_byte_writer.md
SCCB_BYTE_WRITER -- requirements
Module: sccb_byte_writer

Interface
REQ-001 Parameter: CLK_DIV, default 125, clk cycles per SCL quarter-period (50 MHz -> 100 kHz SCL); legal range 2..65535.
REQ-002 clk  input  1  system clock; sole clock, all state updates on its rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 i2cStrobe  input  1  one-cycle request to transmit dataToSend.
REQ-005 dataToSend  input  8  byte to transmit, MSB first.
REQ-006 lastTransfer  input  1  sampled with i2cStrobe; 1 = issue STOP after this byte.
REQ-007 sda  output  1  SCCB data line (1 = released/high).
REQ-008 scl  output  1  SCCB clock line.
REQ-009 busy  output  1  high while an accepted byte (and its STOP, if any) is in flight.

Function
REQ-010 States: IDLE, START, BIT, ACK, HOLD, STOP; every state advances in quarter-periods of exactly CLK_DIV cycles, timed by a 16-bit down counter.
REQ-011 Acceptance: i2cStrobe high in IDLE or HOLD latches dataToSend and lastTransfer; busy goes high the next cycle (latency 1).
REQ-012 i2cStrobe while busy=1 is ignored; latched byte and flags are unaffected.
REQ-013 IDLE: sda=1, scl=1; strobe -> START.
REQ-014 START (2 quarters): q0 sda=0 scl=1; q1 sda=0 scl=0; -> BIT with bit index 7.
REQ-015 BIT (4 quarters per bit): q0/q1 scl=0, sda=current bit; q2/q3 scl=1, sda held; after bit 0 -> ACK.
REQ-016 ACK (4 quarters): sda=1 (don't-care bit), scl 0,0,1,1; then STOP if lastTransfer latched, else HOLD.
REQ-017 HOLD: scl=0, sda=1, busy=0; strobe -> BIT directly (no repeated START).
REQ-018 STOP (3 quarters): q0 scl=0 sda=0; q1 scl=1 sda=0; q2 scl=1 sda=1; -> IDLE.
REQ-019 busy falls on the cycle state enters HOLD or IDLE; byte with START and STOP = 41 quarters of busy, byte from HOLD without STOP = 36 quarters, from HOLD with STOP = 39.
REQ-020 sda changes only while scl=0, except the START and STOP edges.
REQ-021 A strobe in the same cycle busy falls is not accepted (state not yet IDLE/HOLD); accepted from the following cycle.

Reset
REQ-022 reset: state IDLE, sda=1, scl=1, busy=0, counter and bit index cleared, latched byte cleared; takes effect on the next clk edge.
REQ-023 reset mid-transfer aborts immediately with no STOP generated; lines return high on that same edge.

Configuration
REQ-024 Macro SCCB_ACK_CHECK_EN defined: adds input sdaIn (1) and output ackErr (1); sdaIn sampled at the last cycle of ACK q2; if 1, ackErr set and held until reset; transfer otherwise unchanged.
REQ-025 SCCB_ACK_CHECK_EN undefined: sdaIn and ackErr absent; ACK bit is not sampled.

Verification (CLK_DIV=4)
REQ-026 Reset, then strobe dataToSend=0x42, lastTransfer=1 -> busy high 1 cycle later for 164 cycles; scl/sda decode START, 0x42 MSB first, ACK, STOP; busy=0, sda=1, scl=1 after.
REQ-027 Strobe 0x21 lastTransfer=0, then in HOLD strobe 0x12 lastTransfer=1 -> single START, bytes 0x21,0x12, one STOP; first busy 152 cycles, second 156; scl=0 during HOLD.
REQ-028 Strobe 0xFF with lastTransfer=1, then strobe 0x00 at cycle 20 while busy -> ignored; only 0xFF on bus, no second START.
REQ-029 Strobe 0xA5, assert reset at cycle 60 (mid-BIT) -> next edge sda=1 scl=1 busy=0; fresh strobe 0x5A transmits correctly with START.
REQ-030 SCCB_ACK_CHECK_EN defined, sdaIn=1 during ACK -> ackErr=1 after ACK q2 and held; sdaIn=0 with a fresh reset -> ackErr stays 0.
REQ-031 Checker over all scenarios: sda never changes while scl=1 except START/STOP edges; every scl high/low phase is an exact multiple of 4 cycles.
